// File: rtl/saw_ctrl_pkg.sv
// saw_ctrl_pkg: shared types and constants for the
// sawtooth note controller and its octave decoder.
package saw_ctrl_pkg;

  localparam int NOTE_W  = 7;
  localparam int SEMIS   = 12;
  localparam int MAX_OCT = 10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_ATTACK  = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  // round(32768 * 2^(s/12)), top octave of the note range
  localparam logic [15:0] BASE_INC [SEMIS] = '{
    16'd32768,
    16'd34716,
    16'd36781,
    16'd38968,
    16'd41285,
    16'd43740,
    16'd46341,
    16'd49097,
    16'd52016,
    16'd55109,
    16'd58386,
    16'd61858
  };

endpackage

// File: rtl/saw_note_ctrl_if.sv
// saw_note_ctrl_if: note-event valid/ready channel
// from the pin decoder into the note controller.
interface saw_note_ctrl_if;
  import saw_ctrl_pkg::*;

  logic              ev_valid;
  logic              ev_ready;
  logic              ev_on;
  logic [NOTE_W-1:0] ev_note;

  modport master (
    output ev_valid,
    output ev_on,
    output ev_note,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_on,
    input  ev_note,
    output ev_ready
  );

endinterface

// File: rtl/saw_note_decode.sv
// saw_note_decode: serial note -> (octave, semitone)
// split by repeated subtract-12, then table shift.
module saw_note_decode
  import saw_ctrl_pkg::*;
#(
  parameter int INC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NOTE_W-1:0] note,
  output logic              done,
  output logic [INC_W-1:0]  inc
);

  logic              busy_q;
  logic [NOTE_W-1:0] rem_q;
  logic [3:0]        oct_q;
  logic [15:0]       base;
  logic [3:0]        sh;

  assign done = busy_q && (rem_q < NOTE_W'(SEMIS));
  assign base = BASE_INC[rem_q[3:0]];
  assign sh   = 4'(MAX_OCT) - oct_q;
  assign inc  = INC_W'(base) >> sh;

  // one subtract-12 step per cycle until the remainder is a semitone
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      rem_q  <= '0;
      oct_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      rem_q  <= note;
      oct_q  <= '0;
    end else if (busy_q) begin
      if (done) begin
        busy_q <= 1'b0;
      end else begin
        rem_q <= rem_q - NOTE_W'(SEMIS);
        oct_q <= oct_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/saw_note_ctrl.sv
// saw_note_ctrl: note-event handshake, decode launch,
// envelope prescaler and attack/sustain/release FSM.
module saw_note_ctrl
  import saw_ctrl_pkg::*;
#(
  parameter int INC_W    = 16,
  parameter int AMP_W    = 8,
  parameter int ATK_STEP = 64,
  parameter int REL_STEP = 32,
  parameter int TICK_DIV = 256
) (
  input  logic             clk,
  input  logic             rst,
  saw_note_ctrl_if.slave   ev,
  output logic [INC_W-1:0] inc_out,
  output logic [AMP_W-1:0] amp_out,
  output logic             osc_en,
  output logic [2:0]       state_out
);

  localparam int PW = $clog2(TICK_DIV);

  localparam logic [AMP_W-1:0] AMP_MAX = '1;
  localparam logic [AMP_W-1:0] ATK = AMP_W'(ATK_STEP);
  localparam logic [AMP_W-1:0] REL = AMP_W'(REL_STEP);
  localparam logic [PW-1:0] TLAST = PW'(TICK_DIV - 1);

  state_t            state_q, state_d;
  logic [AMP_W-1:0]  amp_q, amp_d;
  logic [INC_W-1:0]  inc_q, inc_d;
  logic              osc_q, osc_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [PW-1:0]     presc_q;

  logic              tick;
  logic              ready;
  logic              accept;
  logic              acc_on;
  logic              acc_rel;
  logic              playing;
  logic              dec_start;
  logic              dec_done;
  logic [INC_W-1:0]  dec_inc;

  assign ready       = (state_q != S_DECODE);
  assign ev.ev_ready = ready;
  assign accept      = ev.ev_valid && ready;

  assign playing = (state_q == S_ATTACK) ||
                   (state_q == S_SUSTAIN);

  assign acc_on  = accept && ev.ev_on;
  assign acc_rel = accept && !ev.ev_on &&
                   playing &&
                   (ev.ev_note == note_q);

  assign tick = (presc_q == TLAST);

  assign inc_out   = inc_q;
  assign amp_out   = amp_q;
  assign osc_en    = osc_q;
  assign state_out = state_q;

  saw_note_decode #(
    .INC_W (INC_W)
  ) u_dec (
    .clk   (clk),
    .rst   (rst),
    .start (dec_start),
    .note  (ev.ev_note),
    .done  (dec_done),
    .inc   (dec_inc)
  );

  // free-running envelope prescaler, untouched by events
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // state and envelope registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      amp_q   <= '0;
      inc_q   <= '0;
      osc_q   <= 1'b0;
      note_q  <= '0;
    end else begin
      state_q <= state_d;
      amp_q   <= amp_d;
      inc_q   <= inc_d;
      osc_q   <= osc_d;
      note_q  <= note_d;
    end
  end

  // accepted events win over decode/envelope work
  always_comb begin
    state_d   = state_q;
    amp_d     = amp_q;
    inc_d     = inc_q;
    osc_d     = osc_q;
    note_d    = note_q;
    dec_start = 1'b0;
    unique case (1'b1)
      acc_on: begin
        note_d    = ev.ev_note;
        dec_start = 1'b1;
        state_d   = S_DECODE;
      end
      acc_rel: begin
        state_d = S_RELEASE;
      end
      default: begin
        unique case (state_q)
          S_DECODE: begin
            if (dec_done) begin
              inc_d   = dec_inc;
              osc_d   = 1'b1;
              state_d = S_ATTACK;
            end
          end
          S_ATTACK: begin
            if (tick) begin
              if (amp_q > AMP_MAX - ATK) begin
                amp_d   = AMP_MAX;
                state_d = S_SUSTAIN;
              end else begin
                amp_d = amp_q + ATK;
              end
            end
          end
          S_RELEASE: begin
            if (tick) begin
              if (amp_q <= REL) begin
                amp_d   = '0;
                osc_d   = 1'b0;
                state_d = S_IDLE;
              end else begin
                amp_d = amp_q - REL;
              end
            end
          end
          default: begin
          end
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_saw_note_ctrl.sv
// tb_saw_note_ctrl: directed + random events against a
// behavioural note/envelope model, queue scoreboard.
module tb_saw_note_ctrl;
  import saw_ctrl_pkg::*;

  localparam int INC_W = 16;
  localparam int AMP_W = 8;
  localparam int ATK   = 64;
  localparam int REL   = 32;
  localparam int TD    = 4;
  localparam int AMAX  = 255;

  logic             clk = 1'b0;
  logic             rst;
  logic [INC_W-1:0] inc_out;
  logic [AMP_W-1:0] amp_out;
  logic             osc_en;
  logic [2:0]       state_out;

  saw_note_ctrl_if ev_if();

  saw_note_ctrl #(
    .INC_W    (INC_W),
    .AMP_W    (AMP_W),
    .ATK_STEP (ATK),
    .REL_STEP (REL),
    .TICK_DIV (TD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ev        (ev_if),
    .inc_out   (inc_out),
    .amp_out   (amp_out),
    .osc_en    (osc_en),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [7:0]  amp;
    logic [15:0] inc;
    logic        osc;
    logic        rdy;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  state_t m_st = S_IDLE;
  int m_amp = 0, m_inc = 0, m_osc = 0, m_cur = 0;
  int m_dleft = 0, m_pend = 0, m_presc = 0;

  function automatic int ref_inc(input int note);
    int  s;
    int  o;
    real b;
    s = note % 12;
    o = note / 12;
    b = 32768.0 * (2.0 ** (real'(s) / 12.0));
    return $rtoi(b + 0.5) >> (10 - o);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0d expected %0d",
               nm, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit v,
                            input bit on, input int note,
                            output bit acc);
    bit tick;
    bit moved;
    acc   = 1'b0;
    moved = 1'b0;
    if (r) begin
      m_st = S_IDLE; m_amp = 0; m_inc = 0; m_osc = 0;
      m_cur = 0; m_dleft = 0; m_presc = 0;
    end else begin
      tick    = (m_presc == TD - 1);
      m_presc = (m_presc + 1) % TD;
      if (v && m_st != S_DECODE) begin
        acc = 1'b1;
        if (on) begin
          m_cur   = note;
          m_dleft = note / 12;
          m_pend  = ref_inc(note);
          m_st    = S_DECODE;
          moved   = 1'b1;
        end else if ((m_st == S_ATTACK ||
                      m_st == S_SUSTAIN) &&
                     note == m_cur) begin
          m_st  = S_RELEASE;
          moved = 1'b1;
        end
      end
      if (!moved) begin
        if (m_st == S_DECODE) begin
          if (m_dleft == 0) begin
            m_inc = m_pend; m_osc = 1; m_st = S_ATTACK;
          end else begin
            m_dleft--;
          end
        end else if (m_st == S_ATTACK && tick) begin
          if (m_amp + ATK > AMAX) begin
            m_amp = AMAX; m_st = S_SUSTAIN;
          end else begin
            m_amp += ATK;
          end
        end else if (m_st == S_RELEASE && tick) begin
          if (m_amp <= REL) begin
            m_amp = 0; m_osc = 0; m_st = S_IDLE;
          end else begin
            m_amp -= REL;
          end
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit v,
                     input bit on, input int note,
                     output bit acc);
    exp_t e;
    @(negedge clk);
    rst            = r;
    ev_if.ev_valid = v;
    ev_if.ev_on    = on;
    ev_if.ev_note  = 7'(note);
    model_step(r, v, on, note, acc);
    e.st  = 3'(m_st);
    e.amp = 8'(m_amp);
    e.inc = 16'(m_inc);
    e.osc = m_osc[0];
    e.rdy = (m_st != S_DECODE);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, a);
  endtask

  task automatic send(input bit on, input int note);
    bit a;
    a = 1'b0;
    for (int i = 0; i < 20 && !a; i++)
      cyc(0, 1, on, note, a);
    if (!a) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout note=%0d", note);
    end
  endtask

  task automatic wait_amp(input int target);
    for (int i = 0; i < 200 && m_amp != target; i++)
      idle(1);
    if (m_amp != target) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_amp got %0d expected %0d",
               m_amp, target);
    end
  endtask

  // scoreboard monitor: one expectation per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_state", 32'(state_out), 32'(e.st));
        chk("sb_amp", 32'(amp_out), 32'(e.amp));
        chk("sb_inc", 32'(inc_out), 32'(e.inc));
        chk("sb_osc", 32'(osc_en), 32'(e.osc));
        chk("sb_ready", 32'(ev_if.ev_ready),
            32'(e.rdy));
      end
    end
  end

  initial begin
    bit acc;
    bit hv;
    bit hon;
    bit r;
    int hn;
    rst            = 1'b1;
    ev_if.ev_valid = 1'b0;
    ev_if.ev_on    = 1'b0;
    ev_if.ev_note  = '0;

    cyc(1, 0, 0, 0, acc);
    cyc(1, 0, 0, 0, acc);
    idle(1);
    chk("rst_state", 32'(state_out), 32'(S_IDLE));
    chk("rst_amp", 32'(amp_out), 0);
    chk("rst_inc", 32'(inc_out), 0);
    chk("rst_osc", 32'(osc_en), 0);
    chk("rst_ready", 32'(ev_if.ev_ready), 1);

    send(1, 69);
    idle(6);
    chk("n69_busy", 32'(ev_if.ev_ready), 0);
    idle(1);
    chk("n69_inc", 32'(inc_out), 1722);
    chk("n69_osc", 32'(osc_en), 1);
    idle(24);
    chk("n69_sus", 32'(state_out), 32'(S_SUSTAIN));
    chk("n69_amp", 32'(amp_out), 255);

    send(0, 60);
    idle(8);
    chk("off_miss", 32'(state_out), 32'(S_SUSTAIN));
    send(0, 69);
    idle(40);
    chk("rel_state", 32'(state_out), 32'(S_IDLE));
    chk("rel_amp", 32'(amp_out), 0);
    chk("rel_osc", 32'(osc_en), 0);
    chk("rel_inc", 32'(inc_out), 1722);

    send(1, 0);
    idle(2);
    chk("n0_inc", 32'(inc_out), 32);
    idle(10);
    send(1, 120);
    idle(12);
    chk("n120_inc", 32'(inc_out), 32768);
    send(1, 60);
    send(0, 60);
    idle(7);
    chk("n60_inc", 32'(inc_out), 1024);

    send(1, 60);
    idle(30);
    send(0, 60);
    wait_amp(127);
    send(1, 60);
    idle(20);

    cyc(1, 0, 0, 0, acc);
    send(1, 60);
    wait_amp(128);
    cyc(1, 0, 0, 0, acc);
    idle(1);
    chk("mid_rst_amp", 32'(amp_out), 0);
    chk("mid_rst_st", 32'(state_out), 32'(S_IDLE));

    hv  = 1'b0;
    hon = 1'b0;
    hn  = 0;
    acc = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!(hv && !acc)) begin
        hv  = ($urandom_range(0, 5) == 0);
        hon = ($urandom_range(0, 2) == 0);
        hn  = ($urandom_range(0, 1) == 1) ?
              m_cur : int'($urandom_range(0, 127));
      end
      r = ($urandom_range(0, 399) == 0);
      cyc(r, hv, hon, hn, acc);
    end
    idle(2);

    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d left, expected 0",
               q.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
